// File: rtl/peak_find.sv
// peak_find: locates the highest-vote pixel of each raster frame and hands it off over a valid/ready port.
// Ports: Clk, Reset          - sole clock, synchronous active-high reset
//        PixelIn             - vote count, one pixel per clock
//        FrameIn, LineIn     - one-cycle pulses on the first pixel of a frame / line
//        PeakReady           - consumer accepts the current result
//        PeakValid           - result registers hold an unconsumed result
//        PeakX, PeakY        - column/row of the winning pixel of the last completed frame
//        PeakVotes           - vote count of that pixel
//        PeakFound           - PeakVotes >= MIN_VOTES
//        Overrun             - sticky; a result was overwritten before acceptance
module peak_find #(
    parameter int PIX_W     = 11,
    parameter int COORD_W   = 8,
    parameter int MIN_VOTES = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [PIX_W-1:0]   PixelIn,
    input  logic               FrameIn,
    input  logic               LineIn,
    input  logic               PeakReady,
    output logic               PeakValid,
    output logic [COORD_W-1:0] PeakX,
    output logic [COORD_W-1:0] PeakY,
    output logic [PIX_W-1:0]   PeakVotes,
    output logic               PeakFound,
    output logic               Overrun
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [COORD_W-1:0] CMAX = '1;
    state_t state, nextState;
    logic [COORD_W-1:0] col, row, curCol, curRow, candX, candY;
    logic [PIX_W-1:0] candVotes;
    logic publish, better;
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= nextState;
    end
    always_comb nextState = (state == IDLE && FrameIn) ? SCAN : state;
    always_comb begin
        publish = state == SCAN && FrameIn;
        better  = state == SCAN && PixelIn > candVotes;
    end
    // Position of the pixel on the bus this cycle; both counters saturate instead of wrapping.
    always_comb begin
        curCol = LineIn ? '0 : (col == CMAX ? col : col + COORD_W'(1));
        curRow = FrameIn ? '0 : (LineIn && row != CMAX ? row + COORD_W'(1) : row);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= curCol;
            row <= curRow;
        end
    end
    // Strict compare keeps the first raster-order occurrence on ties; FrameIn re-seeds at (0,0).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            candVotes <= '0;
            candX     <= '0;
            candY     <= '0;
        end else if (FrameIn) begin
            candVotes <= PixelIn;
            candX     <= '0;
            candY     <= '0;
        end else if (better) begin
            candVotes <= PixelIn;
            candX     <= curCol;
            candY     <= curRow;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PeakValid <= 1'b0;
            PeakX     <= '0;
            PeakY     <= '0;
            PeakVotes <= '0;
            PeakFound <= 1'b0;
            Overrun   <= 1'b0;
        end else if (publish) begin
            PeakValid <= 1'b1;
            PeakX     <= candX;
            PeakY     <= candY;
            PeakVotes <= candVotes;
            PeakFound <= candVotes >= PIX_W'(MIN_VOTES);
            Overrun   <= Overrun | (PeakValid & ~PeakReady);
        end else if (PeakReady) begin
            PeakValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_peak_find.sv
// tb_peak_find: scoreboard bench for peak_find; frame results are queued when the closing FrameIn is driven.
module tb_peak_find;
    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [10:0] v;
        logic        f;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] PixelIn = '0;
    logic        FrameIn = 1'b0;
    logic        LineIn = 1'b0;
    logic        PeakReady = 1'b0;
    logic        PeakValid, PeakFound, Overrun;
    logic [7:0]  PeakX, PeakY;
    logic [10:0] PeakVotes;

    int   nCmp = 0;
    int   nBad = 0;
    int   pix[$];
    res_t sbQ[$];
    res_t prevExp;
    bit   scanning = 0;

    peak_find dut (
        .Clk(Clk), .Reset(Reset), .PixelIn(PixelIn), .FrameIn(FrameIn), .LineIn(LineIn),
        .PeakReady(PeakReady), .PeakValid(PeakValid), .PeakX(PeakX), .PeakY(PeakY),
        .PeakVotes(PeakVotes), .PeakFound(PeakFound), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        FrameIn = 1'b0;
        LineIn = 1'b0;
        PixelIn = '0;
        tick();
        Reset = 1'b0;
        scanning = 0;
        sbQ.delete();
    endtask

    task automatic fill(input int n, input int val);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(val);
    endtask

    // Drives one w x h frame from pix; the previous frame's expected result is queued on FrameIn.
    task automatic runFrame(input int w, input int h);
        res_t e;
        e.v = 11'(pix[0]);
        e.x = 0;
        e.y = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                PixelIn = 11'(pix[r*w+c]);
                LineIn = (c == 0);
                FrameIn = (r == 0 && c == 0);
                if (FrameIn && scanning) sbQ.push_back(prevExp);
                if (!(r == 0 && c == 0) && pix[r*w+c] > int'(e.v)) begin
                    e.v = 11'(pix[r*w+c]);
                    e.x = 8'(c > 255 ? 255 : c);
                    e.y = 8'(r > 255 ? 255 : r);
                end
                tick();
            end
        end
        FrameIn = 1'b0;
        LineIn = 1'b0;
        PixelIn = '0;
        e.f = e.v >= 4;
        prevExp = e;
        scanning = 1;
    endtask

    task automatic flush();
        fill(1, 0);
        runFrame(1, 1);
    endtask

    task automatic test_reset();
        doReset();
        nCmp += 6;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL reset_valid got %0b want 0", PeakValid); end
        if (PeakX !== 8'd0) begin nBad++; $display("FAIL reset_x got %0d want 0", PeakX); end
        if (PeakY !== 8'd0) begin nBad++; $display("FAIL reset_y got %0d want 0", PeakY); end
        if (PeakVotes !== 11'd0) begin nBad++; $display("FAIL reset_votes got %0d want 0", PeakVotes); end
        if (PeakFound !== 1'b0) begin nBad++; $display("FAIL reset_found got %0b want 0", PeakFound); end
        if (Overrun !== 1'b0) begin nBad++; $display("FAIL reset_overrun got %0b want 0", Overrun); end
    endtask

    task automatic test_basic();
        res_t e;
        doReset();
        fill(12, 0);
        pix[1*4+2] = 9;
        runFrame(4, 3);
        nCmp++;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL basic_early got valid %0b want 0", PeakValid); end
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 5;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL basic_valid got %0b want 1", PeakValid); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL basic_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL basic_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL basic_votes got %0d want %0d", PeakVotes, e.v); end
        if (PeakFound !== e.f) begin nBad++; $display("FAIL basic_found got %0b want %0b", PeakFound, e.f); end
        PeakReady = 1'b1;
        tick();
        PeakReady = 1'b0;
        nCmp++;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL basic_accept got valid %0b want 0", PeakValid); end
    endtask

    task automatic test_tie_and_weak();
        res_t e;
        doReset();
        fill(12, 2);
        pix[0*4+1] = 7;
        pix[2*4+3] = 7;
        runFrame(4, 3);
        fill(12, 1);
        pix[2*4+2] = 3;
        pix[0*4+3] = 2;
        runFrame(4, 3);
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 4;
        if (PeakX !== e.x) begin nBad++; $display("FAIL tie_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL tie_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL tie_votes got %0d want %0d", PeakVotes, e.v); end
        if (PeakFound !== e.f) begin nBad++; $display("FAIL tie_found got %0b want %0b", PeakFound, e.f); end
        PeakReady = 1'b1;
        tick();
        PeakReady = 1'b0;
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 5;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL weak_valid got %0b want 1", PeakValid); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL weak_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL weak_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL weak_votes got %0d want %0d", PeakVotes, e.v); end
        if (PeakFound !== e.f) begin nBad++; $display("FAIL weak_found got %0b want %0b", PeakFound, e.f); end
    endtask

    task automatic test_overrun();
        res_t e;
        doReset();
        fill(6, 0);
        pix[4] = 5;
        runFrame(3, 2);
        fill(6, 1);
        pix[2] = 8;
        runFrame(3, 2);
        fill(6, 0);
        pix[3] = 12;
        runFrame(3, 2);
        void'(sbQ.pop_front());
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 5;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL ovr_valid got %0b want 1", PeakValid); end
        if (Overrun !== 1'b1) begin nBad++; $display("FAIL ovr_flag got %0b want 1", Overrun); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL ovr_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL ovr_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL ovr_votes got %0d want %0d", PeakVotes, e.v); end
        PeakReady = 1'b1;
        tick();
        PeakReady = 1'b0;
        nCmp++;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL ovr_accept got valid %0b want 0", PeakValid); end
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 4;
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL ovr_next_votes got %0d want %0d", PeakVotes, e.v); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL ovr_next_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL ovr_next_y got %0d want %0d", PeakY, e.y); end
        if (Overrun !== 1'b1) begin nBad++; $display("FAIL ovr_sticky got %0b want 1", Overrun); end
        PeakReady = 1'b1;
        tick();
        PeakReady = 1'b0;
        nCmp += 2;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL ovr_accept2 got valid %0b want 0", PeakValid); end
        if (Overrun !== 1'b1) begin nBad++; $display("FAIL ovr_sticky2 got %0b want 1", Overrun); end
    endtask

    task automatic test_back_to_back();
        res_t e;
        doReset();
        fill(4, 0);
        pix[1] = 6;
        runFrame(2, 2);
        fill(4, 0);
        pix[3] = 10;
        runFrame(2, 2);
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 2;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL b2b_first_valid got %0b want 1", PeakValid); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL b2b_first_votes got %0d want %0d", PeakVotes, e.v); end
        PeakReady = 1'b1;
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 5;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL b2b_valid got %0b want 1", PeakValid); end
        if (Overrun !== 1'b0) begin nBad++; $display("FAIL b2b_overrun got %0b want 0", Overrun); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL b2b_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL b2b_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL b2b_votes got %0d want %0d", PeakVotes, e.v); end
        tick();
        PeakReady = 1'b0;
        nCmp++;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL b2b_accept got valid %0b want 0", PeakValid); end
    endtask

    task automatic test_saturate();
        res_t e;
        doReset();
        fill(300, 0);
        pix[290] = 5;
        runFrame(300, 1);
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 4;
        if (PeakX !== e.x) begin nBad++; $display("FAIL sat_x got %0d want %0d", PeakX, e.x); end
        if (PeakX !== 8'd255) begin nBad++; $display("FAIL sat_x_abs got %0d want 255", PeakX); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL sat_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL sat_votes got %0d want %0d", PeakVotes, e.v); end
    endtask

    task automatic test_reset_mid();
        res_t e;
        doReset();
        fill(4, 3);
        runFrame(2, 2);
        fill(4, 20);
        runFrame(2, 2);
        nCmp++;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL mid_pending got valid %0b want 1", PeakValid); end
        doReset();
        nCmp += 2;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL mid_valid got %0b want 0", PeakValid); end
        if (PeakVotes !== 11'd0) begin nBad++; $display("FAIL mid_votes got %0d want 0", PeakVotes); end
        for (int i = 0; i < 3; i++) begin
            PixelIn = 11'd50;
            LineIn = (i == 1);
            tick();
        end
        LineIn = 1'b0;
        PixelIn = '0;
        fill(4, 1);
        pix[3] = 6;
        runFrame(2, 2);
        nCmp++;
        if (PeakValid !== 1'b0) begin nBad++; $display("FAIL mid_nopub got valid %0b want 0", PeakValid); end
        flush();
        e = sbQ.size() ? sbQ.pop_front() : '1;
        nCmp += 4;
        if (PeakValid !== 1'b1) begin nBad++; $display("FAIL mid_pub got valid %0b want 1", PeakValid); end
        if (PeakX !== e.x) begin nBad++; $display("FAIL mid_x got %0d want %0d", PeakX, e.x); end
        if (PeakY !== e.y) begin nBad++; $display("FAIL mid_y got %0d want %0d", PeakY, e.y); end
        if (PeakVotes !== e.v) begin nBad++; $display("FAIL mid_votes2 got %0d want %0d", PeakVotes, e.v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_and_weak();
        test_overrun();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
